// File: rtl/cpu_io_bridge.sv
`timescale 1ns/1ps
// cpu_io_bridge
// Bridges asynchronous CPU I/O strobes to a synchronous one-request/one-ack core
// interface. The read and write strobes are decoded against BASE_ADDR, then
// synchronised and glitch-filtered. A three-state FSM (IDLE/WAIT/HOLD) issues
// exactly one req per CPU access, with a bounded wait for ack.
// Optional feature: define CPU_IO_WAIT_EN to drive the CPU wait_n line;
// otherwise wait_n is tied high and no wait logic exists.
module cpu_io_bridge #(
    parameter int                ADDR_W       = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 6'h26,
    parameter int                PORT_BITS    = 2,
    parameter int                FILTER_DEPTH = 3,
    parameter int                TIMEOUT      = 64
) (
    input  logic                 clk_w,
    input  logic                 reset_n_w,
    input  logic [ADDR_W-1:0]    io_addr,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic [PORT_BITS-1:0] port_sel,
    input  logic [7:0]           cd_in,
    output logic [7:0]           cd_out,
    output logic                 cd_oe,
    output logic                 cs_n,
    output logic                 req,
    output logic                 wrt,
    output logic [PORT_BITS-1:0] adr,
    output logic [7:0]           dbo,
    input  logic [7:0]           dbi,
    input  logic                 ack,
    output logic                 wait_n,
    output logic                 timeout_err
);

    localparam int FW = $clog2(FILTER_DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_DEPTH - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Address decode and CPU-side bus control are purely combinational.
    logic       sel_s;
    logic [1:0] dec_s;      // bit 0 = read strobe, bit 1 = write strobe

    assign sel_s  = (io_addr == BASE_ADDR) && !iorq_n;
    assign cs_n   = !sel_s;
    assign cd_oe  = sel_s && !rd_n;
    assign dec_s  = {sel_s && !wr_n, sel_s && !rd_n};

    // Synchroniser and filter state, one lane per strobe.
    logic [1:0]         sync1_r;
    logic [1:0]         sync2_r;
    logic [1:0]         filt_r;
    logic [1:0][FW-1:0] fcnt_r;
    logic               rd_f_s;
    logic               wr_f_s;

    assign rd_f_s = filt_r[0];
    assign wr_f_s = filt_r[1];

    // Two-flop synchronise each strobe, then flip the filtered level only after
    // FILTER_DEPTH consecutive samples disagree with it.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            filt_r  <= 2'b00;
            fcnt_r  <= '0;
        end else begin
            sync1_r <= dec_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= FW'(0);
                end else if (fcnt_r[i] == FILT_LAST) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= FW'(0);
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FW'(1);
                end
            end
        end
    end

    // FSM and registered request-side outputs.
    state_t               state_r, state_nx;
    logic                 req_r, req_nx;
    logic                 wrt_r, wrt_nx;
    logic [PORT_BITS-1:0] adr_r, adr_nx;
    logic [7:0]           dbo_r, dbo_nx;
    logic [7:0]           rdata_r, rdata_nx;
    logic [TW-1:0]        cnt_r, cnt_nx;
    logic                 terr_r, terr_nx;

    // Next-state logic: one req per access, ack only honoured in WAIT after the
    // req cycle, bounded wait, and HOLD until the CPU drops both strobes.
    always_comb begin
        state_nx = state_r;
        req_nx   = 1'b0;
        wrt_nx   = wrt_r;
        adr_nx   = adr_r;
        dbo_nx   = dbo_r;
        rdata_nx = rdata_r;
        cnt_nx   = cnt_r;
        terr_nx  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx = TW'(0);
                if (rd_f_s ^ wr_f_s) begin
                    adr_nx   = port_sel;
                    dbo_nx   = cd_in;
                    wrt_nx   = wr_f_s;
                    req_nx   = 1'b1;
                    state_nx = WAIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (ack && !req_r) begin
                    state_nx = HOLD;
                    if (!wrt_r) begin
                        rdata_nx = dbi;
                    end else begin
                        rdata_nx = rdata_r;
                    end
                end else if (cnt_r == TO_LAST) begin
                    terr_nx  = 1'b1;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt_r + TW'(1);
                end
            end
            HOLD: begin
                if (!rd_f_s && !wr_f_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = HOLD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Register the FSM state and every request-side output.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            wrt_r   <= 1'b0;
            adr_r   <= '0;
            dbo_r   <= 8'h00;
            rdata_r <= 8'h00;
            cnt_r   <= '0;
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            req_r   <= req_nx;
            wrt_r   <= wrt_nx;
            adr_r   <= adr_nx;
            dbo_r   <= dbo_nx;
            rdata_r <= rdata_nx;
            cnt_r   <= cnt_nx;
            terr_r  <= terr_nx;
        end
    end

    assign req         = req_r;
    assign wrt         = wrt_r;
    assign adr         = adr_r;
    assign dbo         = dbo_r;
    assign cd_out      = rdata_r;
    assign timeout_err = terr_r;

`ifdef CPU_IO_WAIT_EN
    // Stall the CPU while selected and not yet answered; the FSM leaving WAIT
    // on ack or timeout releases it. Reset forces the line high.
    assign wait_n = !(reset_n_w && sel_s && ((state_r == IDLE) || (state_r == WAIT)));
`else
    assign wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_io_bridge.sv
`timescale 1ns/1ps
// Directed testbench for cpu_io_bridge: write, read, glitch, decode, timeout,
// conflict, mid-transaction reset and wait_n behaviour.
module tb_cpu_io_bridge;

    logic       clk_w = 1'b0;
    logic       reset_n_w;
    logic [5:0] io_addr;
    logic       iorq_n, rd_n, wr_n;
    logic [1:0] port_sel;
    logic [7:0] cd_in, cd_out, dbo, dbi;
    logic       cd_oe, cs_n, req, wrt, ack, wait_n, timeout_err;
    logic [1:0] adr;

    int vectors     = 0;
    int miscompares = 0;
    int req_seen;
    int req_first;
    logic wait_first;
    int t;
    logic exp_wait_sel;

    cpu_io_bridge dut (
        .clk_w(clk_w), .reset_n_w(reset_n_w), .io_addr(io_addr),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .port_sel(port_sel),
        .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n),
        .req(req), .wrt(wrt), .adr(adr), .dbo(dbo), .dbi(dbi), .ack(ack),
        .wait_n(wait_n), .timeout_err(timeout_err)
    );

    always #5 clk_w = ~clk_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run n cycles sampling on the falling edge; count reqs and, if asked,
    // return a one-cycle ack two cycles after the first req.
    task automatic run(input int n, input bit give_ack);
        req_seen  = 0;
        req_first = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_w);
            ack = 1'b0;
            if (k == 1) wait_first = wait_n;
            if (req) begin
                req_seen++;
                if (req_first == 0) req_first = k;
            end
            if (give_ack && req_first != 0 && k == req_first + 1) ack = 1'b1;
        end
        ack = 1'b0;
    endtask

    task automatic release_bus();
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        run(10, 1'b0);
    endtask

    initial begin
`ifdef CPU_IO_WAIT_EN
        exp_wait_sel = 1'b0;
`else
        exp_wait_sel = 1'b1;
`endif
        reset_n_w = 1'b0; io_addr = 6'h26; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        port_sel = 2'd0; cd_in = 8'h00; dbi = 8'h00; ack = 1'b0;
        repeat (3) @(negedge clk_w);
        check("rst_req", req, 1'b0);
        check("rst_wrt", wrt, 1'b0);
        check("rst_adr", adr, 2'd0);
        check("rst_dbo", dbo, 8'h00);
        check("rst_cd_out", cd_out, 8'h00);
        check("rst_terr", timeout_err, 1'b0);
        check("rst_wait_n", wait_n, 1'b1);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_cd_oe", cd_oe, 1'b0);
        reset_n_w = 1'b1;
        run(3, 1'b0);

        // Write access
        port_sel = 2'd1; cd_in = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
        run(12, 1'b1);
        check("wr_wait_n_sel", wait_first, exp_wait_sel);
        check("wr_req_count", req_seen, 1);
        check("wr_req_latency", req_first, 6);
        check("wr_wrt", wrt, 1'b1);
        check("wr_adr", adr, 2'd1);
        check("wr_dbo", dbo, 8'hA5);
        check("wr_wait_n_hold", wait_n, 1'b1);
        check("wr_cs_n", cs_n, 1'b0);
        release_bus();
        check("wr_release_no_req", req_seen, 0);

        // Read access, strobe held well past completion
        port_sel = 2'd0; dbi = 8'h3C; iorq_n = 1'b0; rd_n = 1'b0;
        run(14, 1'b1);
        check("rd_req_count", req_seen, 1);
        check("rd_wrt", wrt, 1'b0);
        check("rd_adr", adr, 2'd0);
        check("rd_cd_out", cd_out, 8'h3C);
        check("rd_cd_oe", cd_oe, 1'b1);
        run(10, 1'b0);
        check("rd_no_second_req", req_seen, 0);
        release_bus();

        // Two-cycle write glitch
        iorq_n = 1'b0; wr_n = 1'b0;
        run(2, 1'b0);
        iorq_n = 1'b1; wr_n = 1'b1;
        run(12, 1'b0);
        check("glitch_no_req", req_seen, 0);

        // Address outside the window
        io_addr = 6'h27; iorq_n = 1'b0; wr_n = 1'b0;
        #1;
        check("decode_cs_n", cs_n, 1'b1);
        run(12, 1'b0);
        check("decode_no_req", req_seen, 0);
        io_addr = 6'h26;
        release_bus();

        // Read with no ack: timeout after 64 WAIT cycles, rdata kept
        port_sel = 2'd2; dbi = 8'hFF; iorq_n = 1'b0; rd_n = 1'b0;
        t = 0;
        for (int k = 0; k < 20 && !req; k++) @(negedge clk_w);
        check("to_req", req, 1'b1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_w);
            t++;
            if (timeout_err) break;
        end
        check("to_cycle", t, 64);
        @(negedge clk_w);
        check("to_pulse_end", timeout_err, 1'b0);
        check("to_rdata_kept", cd_out, 8'h3C);
        release_bus();

        // Both strobes together
        iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        run(15, 1'b0);
        check("conflict_no_req", req_seen, 0);
        release_bus();

        // Reset while in WAIT
        port_sel = 2'd3; cd_in = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
        run(7, 1'b0);
        check("rst_mid_req", req_seen, 1);
        reset_n_w = 1'b0;
        #1;
        check("rst_mid_req_low", req, 1'b0);
        check("rst_mid_wrt", wrt, 1'b0);
        check("rst_mid_adr", adr, 2'd0);
        check("rst_mid_dbo", dbo, 8'h00);
        check("rst_mid_cd_out", cd_out, 8'h00);
        check("rst_mid_wait_n", wait_n, 1'b1);
        check("rst_mid_terr", timeout_err, 1'b0);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (2) @(negedge clk_w);
        reset_n_w = 1'b1;
        run(10, 1'b0);
        check("rst_abandon_no_req", req_seen, 0);

        // Access after reset is handled normally
        port_sel = 2'd2; dbi = 8'h77; iorq_n = 1'b0; rd_n = 1'b0;
        run(14, 1'b1);
        check("post_rst_req_count", req_seen, 1);
        check("post_rst_adr", adr, 2'd2);
        check("post_rst_cd_out", cd_out, 8'h77);
        release_bus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_io_bridge.md
CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning the number of decoded upper I/O address bits.
REQ-002 SHALL have parameter BASE_ADDR, default 6'h26, meaning the match value for io_addr ($98-$9B window).
REQ-003 SHALL have parameter PORT_BITS, default 2, meaning the port-select width; the block serves 2^PORT_BITS ports.
REQ-004 SHALL have parameter FILTER_DEPTH, default 3, meaning the number of consecutive equal samples required by the strobe filter.
REQ-005 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for ack.
REQ-006 SHALL have ports, one per line:
 clk_w  input  1  system clock, all state on its rising edge
 reset_n_w  input  1  asynchronous active-low reset
 io_addr  input  ADDR_W  CPU address bits above the port field
 iorq_n, rd_n, wr_n  input  1 each  CPU strobes, asynchronous
 port_sel  input  PORT_BITS  port index (mode pins)
 cd_in  input  8  CPU data bus, input side
 cd_out  output  8  read data to CPU
 cd_oe  output  1  CPU bus output enable
 cs_n  output  1  decoded chip select
 req  output  1  one-cycle request to the core
 wrt  output  1  request is a write
 adr  output  PORT_BITS  latched port index
 dbo  output  8  latched write data
 dbi  input  8  read data from the core
 ack  input  1  core completion, one cycle
 wait_n  output  1  CPU wait request
 timeout_err  output  1  one-cycle timeout pulse
REQ-007 SHALL use reset reset_n_w (asynchronous, active-low) and clock clk_w.

Function
REQ-008 SHALL drive cs_n combinationally as NOT(io_addr==BASE_ADDR AND NOT iorq_n).
REQ-009 SHALL drive cd_oe combinationally as NOT cs_n AND NOT rd_n; cd_out SHALL always equal the rdata register.
REQ-010 SHALL pass the decoded read strobe and the decoded write strobe each through a 2-FF synchronizer followed by a filter whose output changes only after FILTER_DEPTH consecutive equal synchronized samples.
REQ-011 SHALL implement the FSM states IDLE, WAIT and HOLD.
REQ-012 In IDLE, when exactly one filtered strobe is active, the FSM SHALL latch port_sel into adr, cd_in into dbo, and write-strobe-active into wrt; it SHALL assert req for exactly one cycle and enter WAIT.
REQ-013 In IDLE, when both filtered strobes are active, the FSM SHALL stay in IDLE and SHALL NOT issue req.
REQ-014 In WAIT, ack SHALL move the FSM to HOLD; for a read, dbi SHALL be loaded into rdata on that edge.
REQ-015 ack SHALL be ignored in IDLE and HOLD, and in the same cycle that req is asserted.
REQ-016 In WAIT, a cycle counter SHALL run; on reaching TIMEOUT-1 without ack, the FSM SHALL pulse timeout_err for one cycle, leave rdata unchanged and enter HOLD.
REQ-017 In HOLD, the FSM SHALL return to IDLE only when both filtered strobes are inactive, so each CPU access yields exactly one req.
REQ-018 wrt, adr and dbo SHALL remain stable from req until the FSM returns to IDLE.

Reset
REQ-019 Reset SHALL force: state IDLE; req, wrt and timeout_err low; adr, dbo and rdata zero; synchronizers and filters inactive; counter zero; wait_n high.
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction with no further req; the following access SHALL be handled normally.

Configuration
REQ-021 With macro CPU_IO_WAIT_EN defined, wait_n SHALL go low combinationally when cs_n is low and the FSM is in IDLE or WAIT, and SHALL be released on the edge of ack or timeout.
REQ-022 With CPU_IO_WAIT_EN undefined, wait_n SHALL be constant 1 and no wait logic SHALL be synthesized.

Verification
REQ-023 Write test: io_addr=6'h26, port_sel=1, cd_in=8'hA5, wr_n low for 12 cycles, ack returned 2 cycles after req -> exactly one req, wrt=1, adr=1, dbo=8'hA5, req 6 cycles (±1) after wr_n falls.
REQ-024 Read test: port_sel=0, rd_n low, dbi=8'h3C with ack -> cd_out=8'h3C while cd_oe=1; no second req while rd_n is held.
REQ-025 Glitch and decode test: 2-cycle wr_n pulse -> no req; io_addr=6'h27 -> cs_n=1 and no req.
REQ-026 Timeout test: read with ack never asserted -> timeout_err pulses at WAIT cycle 64 and rdata is unchanged.
REQ-027 Conflict and reset test: rd_n and wr_n low together -> no req; reset_n_w low during WAIT -> all outputs at reset values.
REQ-028 Wait test, with CPU_IO_WAIT_EN defined: wait_n is low from cs_n falling until the ack edge; with the macro undefined, wait_n stays 1.
